// File: rtl/trc_pkg.sv
// Shared constants and helpers for the trace subsystem.
package trc_pkg;

  localparam int TRC_TS_W  = 16;
  localparam int TRC_CNT_W = 16;
  localparam int TRC_DEPTH = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/needle_fifo.sv
// Timestamp FIFO: registered head, no fall-through, flush has priority.
module needle_fifo
  import trc_pkg::*;
#(
  parameter int DEPTH = TRC_DEPTH,
  parameter int TS_W  = TRC_TS_W,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [TS_W-1:0] wdata,
  output logic [TS_W-1:0] head,
  output logic            empty,
  output logic            full,
  output logic [AW:0]     level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic            do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  // Empty FIFO presents zero so the head is clean straight out of reset.
  assign head    = empty ? '0 : mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/needle_catcher.sv
// Synchronises the active-low needle, timestamps each falling edge and
// queues the timestamps for valid/ready readout.
module needle_catcher
  import trc_pkg::*;
#(
  parameter int TS_W        = TRC_TS_W,
  parameter int DEPTH       = TRC_DEPTH,
  parameter int CNT_W       = TRC_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  needle,
  input  logic                  arm,
  input  logic                  clear,
  output logic [TS_W-1:0]       ts_data,
  output logic                  ts_valid,
  input  logic                  ts_ready,
  output logic [CNT_W-1:0]      event_count,
  output logic                  overflow,
  output logic [clog2(DEPTH):0] fill_level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_pipe;
  logic                   prev_q, det, evt_q;
  logic                   push, pop, full, empty;
  logic [TS_W-1:0]        ts_cnt;

  // vld_pipe tracks which flops hold real samples, so a needle held low
  // across reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '1;
      prev_q   <= 1'b1;
      vld_pipe <= '0;
      evt_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], needle};
      prev_q   <= sync_q[SYNC_STAGES-1];
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      evt_q    <= det;
    end
  end

  assign det = vld_pipe[SYNC_STAGES] & prev_q & ~sync_q[SYNC_STAGES-1] & arm;

  assign ts_valid = ~empty;
  assign pop      = ts_valid & ts_ready & ~clear;
  assign push     = evt_q & (~full | pop) & ~clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt      <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      ts_cnt      <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (evt_q && event_count != '1) event_count <= event_count + 1'b1;
      if (evt_q && !push)             overflow    <= 1'b1;
    end
  end

  needle_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (clear),
    .wdata   (ts_cnt),
    .head    (ts_data),
    .empty   (empty),
    .full    (full),
    .level   (fill_level)
  );

endmodule

// File: tb/tb_needle_catcher.sv
// Directed bench: default instance plus a narrow instance for wrap/saturation.
module tb_needle_catcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        needle = 1'b1, arm = 1'b1, clear = 1'b0, ts_ready = 1'b0;
  logic [15:0] ts_data;
  logic        ts_valid, overflow;
  logic [15:0] event_count;
  logic [3:0]  fill_level;

  logic        needle2 = 1'b1, arm2 = 1'b1, clear2 = 1'b0, ready2 = 1'b0;
  logic [3:0]  ts_data2;
  logic        ts_valid2, overflow2;
  logic [2:0]  event_count2;
  logic [2:0]  fill_level2;

  int checks = 0, passed = 0, cyc = 0;

  always #5 clk = ~clk;

  needle_catcher dut (
    .clk(clk), .reset_n(reset_n), .needle(needle), .arm(arm), .clear(clear),
    .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
    .event_count(event_count), .overflow(overflow), .fill_level(fill_level)
  );

  needle_catcher #(.TS_W(4), .DEPTH(4), .CNT_W(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .needle(needle2), .arm(arm2), .clear(clear2),
    .ts_data(ts_data2), .ts_valid(ts_valid2), .ts_ready(ready2),
    .event_count(event_count2), .overflow(overflow2), .fill_level(fill_level2)
  );

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  // Cycle 0 is the cycle in which reset is released; counter reads 0 there.
  task automatic do_reset();
    reset_n = 1'b0;
    needle = 1'b1; arm = 1'b1; clear = 1'b0; ts_ready = 1'b0;
    needle2 = 1'b1; arm2 = 1'b1; clear2 = 1'b0; ready2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic pulse(input bit which, input int lo, input int hi);
    if (which) needle2 = 1'b0; else needle = 1'b0;
    repeat (lo) tick();
    if (which) needle2 = 1'b1; else needle = 1'b1;
    repeat (hi) tick();
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (ts_valid !== 1'b0 || ts_data !== 16'd0) $display("FAIL rst_async got v=%0b d=%0d want v=0 d=0", ts_valid, ts_data); else passed++;
    @(negedge clk); reset_n = 1'b1; cyc = 0;
    repeat (50) tick();
    checks++; if (ts_valid !== 1'b0) $display("FAIL idle_valid got %0b want 0", ts_valid); else passed++;
    checks++; if (event_count !== 16'd0) $display("FAIL idle_count got %0d want 0", event_count); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL idle_ovf got %0b want 0", overflow); else passed++;
    checks++; if (fill_level !== 4'd0) $display("FAIL idle_fill got %0d want 0", fill_level); else passed++;
    checks++; if (ts_valid2 !== 1'b0 || event_count2 !== 3'd0 || fill_level2 !== 3'd0) $display("FAIL idle_dut2 got v=%0b c=%0d f=%0d want 0 0 0", ts_valid2, event_count2, fill_level2); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    tick_to(10);
    needle = 1'b0;
    tick_to(13);
    checks++; if (ts_valid !== 1'b0) $display("FAIL single_nofall got %0b want 0", ts_valid); else passed++;
    tick();
    checks++; if (ts_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", ts_valid); else passed++;
    checks++; if (ts_data !== 16'd13) $display("FAIL single_data got %0d want 13", ts_data); else passed++;
    checks++; if (event_count !== 16'd1) $display("FAIL single_count got %0d want 1", event_count); else passed++;
    tick(); needle = 1'b1;
    repeat (6) tick();
    checks++; if (event_count !== 16'd1 || fill_level !== 4'd1) $display("FAIL single_rise got c=%0d f=%0d want 1 1", event_count, fill_level); else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    tick_to(10);
    repeat (10) pulse(1'b0, 4, 4);
    tick_to(94);
    checks++; if (fill_level !== 4'd8) $display("FAIL ovf_fill got %0d want 8", fill_level); else passed++;
    checks++; if (event_count !== 16'd10) $display("FAIL ovf_count got %0d want 10", event_count); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else passed++;
    checks++; if (ts_data !== 16'd13) $display("FAIL ovf_head got %0d want 13", ts_data); else passed++;
    ts_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ts_valid !== 1'b1 || ts_data !== 16'(13 + 8*i))
        $display("FAIL ovf_drain%0d got v=%0b d=%0d want v=1 d=%0d", i, ts_valid, ts_data, 13 + 8*i);
      else passed++;
      tick();
    end
    ts_ready = 1'b0;
    checks++; if (ts_valid !== 1'b0 || fill_level !== 4'd0) $display("FAIL ovf_empty got v=%0b f=%0d want 0 0", ts_valid, fill_level); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", overflow); else passed++;
  endtask

  task automatic test_full_pop();
    do_reset();
    tick_to(10);
    repeat (8) pulse(1'b0, 4, 4);
    needle = 1'b0;
    tick_to(77);
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    needle = 1'b1;
    checks++; if (fill_level !== 4'd8) $display("FAIL fpop_fill got %0d want 8", fill_level); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL fpop_ovf got %0b want 0", overflow); else passed++;
    checks++; if (event_count !== 16'd9) $display("FAIL fpop_count got %0d want 9", event_count); else passed++;
    ts_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ts_data !== 16'(21 + 8*i)) $display("FAIL fpop_drain%0d got %0d want %0d", i, ts_data, 21 + 8*i);
      else passed++;
      tick();
    end
    ts_ready = 1'b0;
  endtask

  task automatic test_arm();
    do_reset();
    arm = 1'b0;
    tick_to(10);
    needle = 1'b0;
    tick_to(14);
    arm = 1'b1;
    tick_to(18);
    needle = 1'b1;
    tick_to(24);
    checks++; if (event_count !== 16'd0 || ts_valid !== 1'b0) $display("FAIL arm_gate got c=%0d v=%0b want 0 0", event_count, ts_valid); else passed++;
    pulse(1'b0, 4, 4);
    checks++; if (event_count !== 16'd1 || fill_level !== 4'd1) $display("FAIL arm_next got c=%0d f=%0d want 1 1", event_count, fill_level); else passed++;
    checks++; if (ts_data !== 16'd27) $display("FAIL arm_ts got %0d want 27", ts_data); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    tick_to(11);
    pulse(1'b1, 4, 0);
    tick_to(31);
    pulse(1'b1, 4, 2);
    checks++; if (fill_level2 !== 3'd2) $display("FAIL wrap_fill got %0d want 2", fill_level2); else passed++;
    checks++; if (ts_data2 !== 4'd14) $display("FAIL wrap_first got %0d want 14", ts_data2); else passed++;
    ready2 = 1'b1; tick(); ready2 = 1'b0;
    checks++; if (ts_data2 !== 4'd2 || fill_level2 !== 3'd1) $display("FAIL wrap_second got d=%0d f=%0d want 2 1", ts_data2, fill_level2); else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    tick_to(10);
    repeat (9) pulse(1'b1, 4, 4);
    checks++; if (event_count2 !== 3'd7) $display("FAIL sat_count got %0d want 7", event_count2); else passed++;
    checks++; if (fill_level2 !== 3'd4 || overflow2 !== 1'b1) $display("FAIL sat_full got f=%0d o=%0b want 4 1", fill_level2, overflow2); else passed++;
    checks++; if (ts_data2 !== 4'd13) $display("FAIL sat_head got %0d want 13", ts_data2); else passed++;
  endtask

  task automatic test_clear_event();
    do_reset();
    tick_to(10);
    repeat (9) pulse(1'b0, 4, 4);
    checks++; if (overflow !== 1'b1 || fill_level !== 4'd8) $display("FAIL clr_pre got o=%0b f=%0d want 1 8", overflow, fill_level); else passed++;
    needle = 1'b0;
    tick_to(85);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    needle = 1'b1;
    checks++; if (fill_level !== 4'd0 || ts_valid !== 1'b0) $display("FAIL clr_fifo got f=%0d v=%0b want 0 0", fill_level, ts_valid); else passed++;
    checks++; if (event_count !== 16'd0 || overflow !== 1'b0) $display("FAIL clr_cnt got c=%0d o=%0b want 0 0", event_count, overflow); else passed++;
    tick_to(90);
    pulse(1'b0, 4, 0);
    checks++; if (ts_data !== 16'd7 || event_count !== 16'd1) $display("FAIL clr_ts got d=%0d c=%0d want 7 1", ts_data, event_count); else passed++;
  endtask

  task automatic test_midreset();
    do_reset();
    tick_to(10);
    needle = 1'b0;
    tick_to(14);
    reset_n = 1'b0;
    #1;
    checks++; if (fill_level !== 4'd0 || event_count !== 16'd0 || ts_valid !== 1'b0) $display("FAIL mrst_async got f=%0d c=%0d v=%0b want 0 0 0", fill_level, event_count, ts_valid); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    tick_to(20);
    checks++; if (event_count !== 16'd0 || ts_valid !== 1'b0) $display("FAIL mrst_low got c=%0d v=%0b want 0 0", event_count, ts_valid); else passed++;
    needle = 1'b1;
    tick_to(25);
    pulse(1'b0, 5, 0);
    checks++; if (event_count !== 16'd1 || ts_data !== 16'd28) $display("FAIL mrst_next got c=%0d d=%0d want 1 28", event_count, ts_data); else passed++;
    needle = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_arm();
    test_wrap();
    test_saturate();
    test_clear_event();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
